// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IN_WAIT  = 2'd1,
        ST_OUT_WAIT = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam int REG_ADDR_W = 3;

    // Wide enough for any datapath width; the top slices off n bits.
    localparam logic [63:0] IO_TIMEOUT_DATA = '1;

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  stall_req
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit    = id_uses_rs & (id_rs == ex_write_reg);
    assign rt_hit    = id_uses_rt & (id_rt == ex_write_reg);
    assign stall_req = ex_mem_read & ex_reg_write & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline, including the IN/OUT port handshakes.
//   state       | meaning
//   ST_RUN      | normal flow; branch flush / load-use stall; IO detect
//   ST_IN_WAIT  | pipeline frozen, in_ready high, waiting for in_valid
//   ST_OUT_WAIT | pipeline frozen, out_valid high, waiting for out_ready
//   ST_RELEASE  | one cycle of unfreeze; MEM/WB captures the IO instruction
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int n       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_MemRead,
    input  logic                  ex_RegWrite,
    input  logic [REG_ADDR_W-1:0] ex_WriteRegister,
    input  logic                  ex_branch_taken,
    input  logic                  mem_IN,
    input  logic                  mem_OUT,
    input  logic [n-1:0]          mem_out_data,
    input  logic                  in_valid,
    input  logic [n-1:0]          in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [n-1:0]          out_data,
    input  logic                  out_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_bubble,
    output logic [n-1:0]          io_rdata,
    output logic                  io_timeout
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lu_stall;
    logic       io_start;
    logic       freeze;

    load_use_detect u_load_use (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_MemRead),
        .ex_reg_write (ex_RegWrite),
        .ex_write_reg (ex_WriteRegister),
        .stall_req    (lu_stall)
    );

    // IO is only detected from RUN, so RELEASE never re-triggers on the same instruction.
    assign io_start = (state == ST_RUN) & (mem_IN | mem_OUT);
    assign freeze   = io_start | (state == ST_IN_WAIT) | (state == ST_OUT_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            io_rdata   <= '0;
            io_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_IN) begin
                        state    <= ST_IN_WAIT;
                        in_ready <= 1'b1;
                        wait_cnt <= '0;
                    end else if (mem_OUT) begin
                        state     <= ST_OUT_WAIT;
                        out_valid <= 1'b1;
                        out_data  <= mem_out_data;
                        wait_cnt  <= '0;
                    end
                end
                ST_IN_WAIT: begin
                    if (in_valid) begin
                        io_rdata <= in_data;
                        in_ready <= 1'b0;
                        state    <= ST_RELEASE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        io_timeout <= 1'b1;
                        io_rdata   <= IO_TIMEOUT_DATA[n-1:0];
                        in_ready   <= 1'b0;
                        state      <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_RELEASE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        io_timeout <= 1'b1;
                        out_valid  <= 1'b0;
                        state      <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RELEASE: state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

    // RELEASE shares the RUN priority so a branch held in EX during the freeze resolves here.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized bench for pipe_stall_ctrl with an in-bench behavioural model and directed anchor checks.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_WriteRegister;
    logic        id_uses_rs, id_uses_rt, ex_MemRead, ex_RegWrite, ex_branch_taken;
    logic        mem_IN, mem_OUT, in_valid, out_ready;
    logic [15:0] mem_out_data, in_data;
    logic        in_ready, out_valid, pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_bubble, io_timeout;
    logic [15:0] out_data, io_rdata;

    int checks = 0;
    int errors = 0;

    // Model: io_kind 0 = no handshake pending, 1 = waiting on IN, 2 = waiting on OUT.
    int          cyc = 0;
    int          io_kind;
    bit          releasing;
    int          deadline;
    logic [15:0] m_rdata, m_odata;
    bit          m_tmo;

    pipe_stall_ctrl #(.n(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_WriteRegister(ex_WriteRegister),
        .ex_branch_taken(ex_branch_taken), .mem_IN(mem_IN), .mem_OUT(mem_OUT),
        .mem_out_data(mem_out_data), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .io_rdata(io_rdata), .io_timeout(io_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        io_kind   = 0;
        releasing = 0;
        deadline  = 0;
        m_rdata   = '0;
        m_odata   = '0;
        m_tmo     = 0;
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst) begin
            model_reset();
        end else if (io_kind == 1) begin
            if (in_valid) begin
                m_rdata = in_data; io_kind = 0; releasing = 1;
            end else if (cyc == deadline) begin
                m_rdata = 16'hFFFF; m_tmo = 1; io_kind = 0; releasing = 1;
            end
        end else if (io_kind == 2) begin
            if (out_ready || cyc == deadline) begin
                if (!out_ready) m_tmo = 1;
                io_kind = 0; releasing = 1;
            end
        end else if (releasing) begin
            releasing = 0;
        end else if (mem_IN) begin
            io_kind = 1; deadline = cyc + TIMEOUT;
        end else if (mem_OUT) begin
            io_kind = 2; deadline = cyc + TIMEOUT; m_odata = mem_out_data;
        end
    endtask

    task automatic compare_all();
        bit frz, lu, e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub;
        frz = (io_kind != 0) || (!releasing && (mem_IN || mem_OUT));
        lu  = ex_MemRead && ex_RegWrite &&
              ((id_uses_rs && id_rs == ex_WriteRegister) || (id_uses_rt && id_rt == ex_WriteRegister));
        {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = 7'b1111_000;
        if (!rst)                 {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = 7'b0000_000;
        else if (frz)             {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = 7'b0000_001;
        else if (ex_branch_taken) {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = 7'b1111_110;
        else if (lu)              {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = 7'b0011_010;
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("ifid_en", 32'(ifid_en), 32'(e_ifid));
        chk("idex_en", 32'(idex_en), 32'(e_idex));
        chk("exmem_en", 32'(exmem_en), 32'(e_exmem));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("memwb_bubble", 32'(memwb_bubble), 32'(e_bub));
        chk("in_ready", 32'(in_ready), 32'(io_kind == 1));
        chk("out_valid", 32'(out_valid), 32'(io_kind == 2));
        chk("out_data", 32'(out_data), 32'(m_odata));
        chk("io_rdata", 32'(io_rdata), 32'(m_rdata));
        chk("io_timeout", 32'(io_timeout), 32'(m_tmo));
    endtask

    // Called just after a rising edge with the next inputs applied.
    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_WriteRegister = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_MemRead = 0; ex_RegWrite = 0; ex_branch_taken = 0;
        mem_IN = 0; mem_OUT = 0; in_valid = 0; out_ready = 0;
        mem_out_data = '0; in_data = '0;
    endtask

    task automatic rand_inputs();
        id_rs            = 3'($urandom_range(0, 3));
        id_rt            = 3'($urandom_range(0, 3));
        ex_WriteRegister = 3'($urandom_range(0, 3));
        id_uses_rs       = ($urandom_range(0, 1) == 1);
        id_uses_rt       = ($urandom_range(0, 1) == 1);
        ex_MemRead       = ($urandom_range(0, 1) == 1);
        ex_RegWrite      = ($urandom_range(0, 3) != 0);
        ex_branch_taken  = ($urandom_range(0, 5) == 0);
        mem_IN           = ($urandom_range(0, 9) == 0);
        mem_OUT          = ($urandom_range(0, 9) == 0);
        mem_out_data     = 16'($urandom);
        in_valid         = ($urandom_range(0, 3) == 0);
        in_data          = 16'($urandom);
        out_ready        = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        #1;
        chk("reset_pc_en", 32'(pc_en), 0);
        chk("reset_bubble", 32'(memwb_bubble), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_io_rdata", 32'(io_rdata), 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        tick(); tick();

        // load-use on rs
        ex_MemRead = 1; ex_RegWrite = 1; ex_WriteRegister = 3'd3; id_rs = 3'd3; id_uses_rs = 1;
        #1;
        chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_ifid_en", 32'(ifid_en), 0);
        chk("lu_idex_flush", 32'(idex_flush), 1);
        tick();
        id_uses_rs = 0;
        #1 chk("lu_unused_pc_en", 32'(pc_en), 1);
        tick();

        // branch beats load-use
        id_uses_rs = 1; ex_branch_taken = 1;
        #1;
        chk("br_lu_ifid_flush", 32'(ifid_flush), 1);
        chk("br_lu_idex_flush", 32'(idex_flush), 1);
        chk("br_lu_pc_en", 32'(pc_en), 1);
        tick();
        clear_inputs();
        tick();

        // IN, in_valid four cycles after detection (also the last allowed wait cycle)
        mem_IN = 1;
        #1;
        chk("in_detect_bubble", 32'(memwb_bubble), 1);
        chk("in_detect_ready", 32'(in_ready), 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            in_valid = (i == 4); in_data = 16'h1234;
            #1;
            chk("in_wait_ready", 32'(in_ready), 1);
            chk("in_wait_bubble", 32'(memwb_bubble), 1);
            tick();
        end
        in_valid = 0;
        #1;
        chk("in_release_rdata", 32'(io_rdata), 32'h1234);
        chk("in_release_bubble", 32'(memwb_bubble), 0);
        chk("in_release_pc_en", 32'(pc_en), 1);
        chk("in_release_timeout", 32'(io_timeout), 0);
        tick();
        mem_IN = 0;
        tick();

        // OUT, out_ready on the first wait cycle; source data changes during the wait
        mem_OUT = 1; mem_out_data = 16'hBEEF;
        tick();
        mem_out_data = 16'h0000; out_ready = 1;
        #1;
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'hBEEF);
        chk("out_wait_pc_en", 32'(pc_en), 0);
        tick();
        out_ready = 0;
        #1;
        chk("out_release_valid", 32'(out_valid), 0);
        chk("out_release_pc_en", 32'(pc_en), 1);
        chk("out_release_rdata", 32'(io_rdata), 32'h1234);
        tick();
        mem_OUT = 0;
        tick();

        // IN timeout
        mem_IN = 1;
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            #1 chk("tmo_wait_flag", 32'(io_timeout), 0);
            tick();
        end
        #1;
        chk("tmo_flag", 32'(io_timeout), 1);
        chk("tmo_rdata", 32'(io_rdata), 32'hFFFF);
        chk("tmo_release_pc_en", 32'(pc_en), 1);
        tick();
        mem_IN = 0;
        tick(); tick();
        chk("tmo_sticky", 32'(io_timeout), 1);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        // reset in the middle of an IN handshake
        clear_inputs();
        for (int i = 0; i < TIMEOUT + 4; i++) tick();
        mem_IN = 1;
        tick(); tick();
        in_valid = 1; in_data = 16'h5555;
        #1 compare_all();
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_io_rdata", 32'(io_rdata), 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_timeout", 32'(io_timeout), 0);
        @(posedge clk);
        model_edge();
        #1 chk("rst_no_capture", 32'(io_rdata), 0);
        rst = 1'b1; mem_IN = 0; in_valid = 0;
        tick();
        chk("rst_run_in_ready", 32'(in_ready), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
